// File: rtl/shift_pkg.sv
// Mode encodings for the parametrised shift register.
// Any controller that drives the mode input should import this package.
package shift_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_FWD  = 2'b01;
    localparam logic [1:0] MODE_REV  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/shift_stage.sv
// One WIDTH-bit register of the shift chain.
// Its next value is chosen from hold, left neighbour, right neighbour or load slice.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_left,
    input  logic [WIDTH-1:0] i_right,
    input  logic [WIDTH-1:0] i_load,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            case (i_mode)
                MODE_FWD:  r_q <= i_left;
                MODE_REV:  r_q <= i_right;
                MODE_LOAD: r_q <= i_load;
                default:   r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/param_shift_register.sv
// This is a DEPTH x WIDTH bidirectional shift register with parallel load.
// It also has a saturating fill counter.
module param_shift_register
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       sin_fwd,
    input  logic [WIDTH-1:0]       sin_rev,
    input  logic [DEPTH*WIDTH-1:0] par_in,
    output logic [WIDTH-1:0]       data_out,
    output logic [WIDTH-1:0]       sout_rev,
    output logic [DEPTH*WIDTH-1:0] par_out,
    output logic [CW-1:0]          fill_cnt,
    output logic                   full
);

    logic [WIDTH-1:0] w_q     [DEPTH];
    logic [WIDTH-1:0] w_left  [DEPTH];
    logic [WIDTH-1:0] w_right [DEPTH];
    logic [CW-1:0]    r_fill;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        // The chain ends take their data from the serial inputs.
        if (i == 0) begin : g_first
            assign w_left[i] = sin_fwd;
        end else begin : g_mid_l
            assign w_left[i] = w_q[i-1];
        end

        if (i == DEPTH - 1) begin : g_last
            assign w_right[i] = sin_rev;
        end else begin : g_mid_r
            assign w_right[i] = w_q[i+1];
        end

        shift_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .i_mode  (mode),
            .i_left  (w_left[i]),
            .i_right (w_right[i]),
            .i_load  (par_in[i*WIDTH +: WIDTH]),
            .o_q     (w_q[i])
        );

        assign par_out[i*WIDTH +: WIDTH] = w_q[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fill <= '0;
        end else begin
            case (mode)
                MODE_LOAD: r_fill <= CW'(DEPTH);
                MODE_FWD, MODE_REV: begin
                    if (r_fill != CW'(DEPTH)) begin
                        r_fill <= r_fill + CW'(1);
                    end
                end
                default: r_fill <= r_fill;
            endcase
        end
    end

    assign data_out = w_q[DEPTH-1];
    assign sout_rev = w_q[0];
    assign fill_cnt = r_fill;
    assign full     = (r_fill == CW'(DEPTH));

endmodule

// File: tb/tb_param_shift_register.sv
// Bench for param_shift_register: it runs vector tables, hand sequences and
// random traffic against an array model.
module tb_param_shift_register;

    localparam logic [1:0] H = 2'b00;
    localparam logic [1:0] F = 2'b01;
    localparam logic [1:0] R = 2'b10;
    localparam logic [1:0] L = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8, DEPTH=4 instance
    logic        rst8;
    logic [1:0]  mode8;
    logic [7:0]  sf8, sr8;
    logic [31:0] pin8;
    logic [7:0]  dout8, srev8;
    logic [31:0] pout8;
    logic [2:0]  fill8;
    logic        full8;

    // WIDTH=1, DEPTH=4 instance
    logic        rst1;
    logic [1:0]  mode1;
    logic        sf1, sr1;
    logic [3:0]  pin1;
    logic        dout1, srev1;
    logic [3:0]  pout1;
    logic [2:0]  fill1;
    logic        full1;

    param_shift_register #(.WIDTH(8), .DEPTH(4)) dut8 (
        .clk      (clk),
        .reset    (rst8),
        .mode     (mode8),
        .sin_fwd  (sf8),
        .sin_rev  (sr8),
        .par_in   (pin8),
        .data_out (dout8),
        .sout_rev (srev8),
        .par_out  (pout8),
        .fill_cnt (fill8),
        .full     (full8)
    );

    param_shift_register #(.WIDTH(1), .DEPTH(4)) dut1 (
        .clk      (clk),
        .reset    (rst1),
        .mode     (mode1),
        .sin_fwd  (sf1),
        .sin_rev  (sr1),
        .par_in   (pin1),
        .data_out (dout1),
        .sout_rev (srev1),
        .par_out  (pout1),
        .fill_cnt (fill1),
        .full     (full1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [31:0] ep,
                        input int ef);
        chk({name, ".par"}, 64'(pout8), 64'(ep));
        chk({name, ".dout"}, 64'(dout8), 64'(ep[31:24]));
        chk({name, ".srev"}, 64'(srev8), 64'(ep[7:0]));
        chk({name, ".fill"}, 64'(fill8), 64'(ef));
        chk({name, ".full"}, 64'(full8), 64'(ef == 4));
    endtask

    task automatic step8(input logic r, input logic [1:0] m,
                         input logic [7:0] f, input logic [7:0] v,
                         input logic [31:0] p);
        @(negedge clk);
        rst8 = r; mode8 = m; sf8 = f; sr8 = v; pin8 = p;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  mode;
        logic [7:0]  sf;
        logic [7:0]  sr;
        logic [31:0] pin;
        logic [31:0] ep;
        int          ef;
    } vec_t;

    vec_t tbl[18];

    // Reference model: stage contents as a plain array plus a word count
    logic [7:0] m_s[4];
    int         m_fill;

    function automatic logic [31:0] m_pack();
        return {m_s[3], m_s[2], m_s[1], m_s[0]};
    endfunction

    initial begin
        rst8 = 1; mode8 = H; sf8 = 0; sr8 = 0; pin8 = 0;
        rst1 = 1; mode1 = H; sf1 = 0; sr1 = 0; pin1 = 0;

        tbl[0]  = '{1, L, 8'h00, 8'h00, 32'hFFFFFFFF, 32'h00000000, 0};
        tbl[1]  = '{0, L, 8'h00, 8'h00, 32'hDEADBEEF, 32'hDEADBEEF, 4};
        tbl[2]  = '{0, R, 8'hFF, 8'h00, 32'h00000000, 32'h00DEADBE, 4};
        tbl[3]  = '{0, L, 8'h00, 8'h00, 32'hDEADBEEF, 32'hDEADBEEF, 4};
        tbl[4]  = '{0, F, 8'h5A, 8'hFF, 32'h00000000, 32'hADBEEF5A, 4};
        tbl[5]  = '{0, L, 8'h00, 8'h00, 32'h01234567, 32'h01234567, 4};
        tbl[6]  = '{0, H, 8'hFF, 8'hEE, 32'hAAAAAAAA, 32'h01234567, 4};
        tbl[7]  = '{0, H, 8'h12, 8'h34, 32'h55555555, 32'h01234567, 4};
        tbl[8]  = '{0, H, 8'h00, 8'hFF, 32'hFFFFFFFF, 32'h01234567, 4};
        tbl[9]  = '{0, H, 8'h99, 8'h77, 32'h00000000, 32'h01234567, 4};
        tbl[10] = '{0, H, 8'h3C, 8'hC3, 32'hCAFEF00D, 32'h01234567, 4};
        tbl[11] = '{1, F, 8'h77, 8'h00, 32'h00000000, 32'h00000000, 0};
        tbl[12] = '{0, F, 8'h11, 8'h00, 32'h00000000, 32'h00000011, 1};
        tbl[13] = '{0, F, 8'h22, 8'h00, 32'h00000000, 32'h00001122, 2};
        tbl[14] = '{0, R, 8'h00, 8'h33, 32'h00000000, 32'h33000011, 3};
        tbl[15] = '{0, F, 8'h44, 8'h00, 32'h00000000, 32'h00001144, 4};
        tbl[16] = '{0, F, 8'h55, 8'h00, 32'h00000000, 32'h00114455, 4};
        tbl[17] = '{1, L, 8'h00, 8'h00, 32'hFFFFFFFF, 32'h00000000, 0};

        for (int i = 0; i < 18; i++) begin
            step8(tbl[i].rst, tbl[i].mode, tbl[i].sf, tbl[i].sr, tbl[i].pin);
            chk8($sformatf("tbl%0d", i), tbl[i].ep, tbl[i].ef);
        end

        // Legacy-equivalent 1-bit chain: serial in 1,0,1,1 -> 4'b1011
        @(negedge clk); rst1 = 1; mode1 = F;
        @(negedge clk); rst1 = 1;
        @(posedge clk); #1;
        chk("w1.rst.par", 64'(pout1), 64'h0);
        chk("w1.rst.fill", 64'(fill1), 64'h0);
        @(negedge clk); rst1 = 0; mode1 = F; sf1 = 1;
        @(negedge clk); sf1 = 0;
        @(negedge clk); sf1 = 1;
        @(negedge clk); sf1 = 1;
        @(negedge clk); mode1 = H; sf1 = 0;
        chk("w1.par", 64'(pout1), 64'hB);
        chk("w1.dout", 64'(dout1), 64'h1);
        chk("w1.srev", 64'(srev1), 64'h1);
        chk("w1.fill", 64'(fill1), 64'h4);
        chk("w1.full", 64'(full1), 64'h1);

        // Fill counter saturates and full rises only after the 4th shift
        step8(1, H, 0, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            step8(0, F, 8'(i), 0, 0);
            chk($sformatf("sat%0d.fill", i), 64'(fill8), 64'(i > 4 ? 4 : i));
            chk($sformatf("sat%0d.full", i), 64'(full8), 64'(i >= 4));
        end

        // Reset while LOAD is requested mid-stream: reset wins
        step8(1, H, 0, 0, 0);
        step8(0, F, 8'hA1, 0, 0);
        step8(0, F, 8'hB2, 0, 0);
        chk8("pre_rst", 32'h0000A1B2, 2);
        step8(1, L, 8'hCC, 8'hDD, 32'h89ABCDEF);
        chk8("rst_load", 32'h0, 0);
        step8(0, R, 0, 8'h7E, 0);
        chk8("post_rst", 32'h7E000000, 1);

        // Hold with random don't-care inputs after a load
        step8(0, L, 0, 0, 32'h01234567);
        for (int i = 0; i < 5; i++) begin
            step8(0, H, 8'($urandom), 8'($urandom), $urandom);
            chk8($sformatf("hold%0d", i), 32'h01234567, 4);
        end

        // Random traffic against the array model
        step8(1, H, 0, 0, 0);
        for (int k = 0; k < 4; k++) m_s[k] = 8'h00;
        m_fill = 0;
        for (int i = 0; i < 400; i++) begin
            logic        r;
            logic [1:0]  m;
            logic [7:0]  f, v;
            logic [31:0] p;
            r = ($urandom_range(0, 24) == 0);
            m = 2'($urandom);
            f = 8'($urandom);
            v = 8'($urandom);
            p = $urandom;
            step8(r, m, f, v, p);
            if (r) begin
                for (int k = 0; k < 4; k++) m_s[k] = 8'h00;
                m_fill = 0;
            end else if (m == F) begin
                for (int k = 3; k > 0; k--) m_s[k] = m_s[k-1];
                m_s[0] = f;
                m_fill = (m_fill < 4) ? m_fill + 1 : 4;
            end else if (m == R) begin
                for (int k = 0; k < 3; k++) m_s[k] = m_s[k+1];
                m_s[3] = v;
                m_fill = (m_fill < 4) ? m_fill + 1 : 4;
            end else if (m == L) begin
                for (int k = 0; k < 4; k++) m_s[k] = p[k*8 +: 8];
                m_fill = 4;
            end
            chk8($sformatf("rnd%0d", i), m_pack(), m_fill);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
